// File: rtl/rf_pkg.sv
// Shared register-file constants for the 16-bit MIPS datapath.
// CPU, forwarding unit and benches import these so defaults stay in one place.
package rf_pkg;
    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 4;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_word.sv
// One architectural register: WIDTH-bit storage with write enable and sync reset.
module rf_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with writeback-to-read bypass and a per-register pending-write
// scoreboard that decode uses to stall on RAW hazards.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int WIDTH  = RF_WIDTH,
    parameter  int NREGS  = RF_NREGS,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready
);
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NREGS-1:0]            pending;
    logic [NREGS-1:0]            pend_nxt;
    logic                        hit1, hit2, hit_iss;

    assign regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_word
        rf_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (regwrite && wr == ADDR_W'(i)),
            .d     (wd),
            .q     (regs[i])
        );
    end

    // Same-cycle writeback satisfies a read and retires its pending bit.
    assign hit1    = regwrite && wr == rr1;
    assign hit2    = regwrite && wr == rr2;
    assign hit_iss = regwrite && wr == issue_rd;

    assign rd1 = (rr1 == ZR) ? '0 : (hit1 ? wd : regs[rr1]);
    assign rd2 = (rr2 == ZR) ? '0 : (hit2 ? wd : regs[rr2]);

    assign busy1 = (rr1 != ZR) && pending[rr1] && !hit1;
    assign busy2 = (rr2 != ZR) && pending[rr2] && !hit2;

    // Kept free of issue_valid so decode can gate issue on it without a loop.
    assign issue_ready = (issue_rd == ZR) || !pending[issue_rd] || hit_iss;

    always_comb begin
        pend_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            // Set beats clear so a back-to-back writer keeps the register pending.
            pend_nxt[i] = (issue_valid && issue_ready && issue_rd == ADDR_W'(i))
                        | (pending[i] & ~(regwrite && wr == ADDR_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= pend_nxt;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, random run against a behavioural
// model, and a reset-mid-operation sequence on a 32-bit x 8 instance.
module tb_reg_file_sb;
    import rf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit x 4 instance
    logic        a_rst, a_rw, a_iv, a_b1, a_b2, a_rdy;
    logic [1:0]  a_wr, a_ird, a_rr1, a_rr2;
    logic [15:0] a_wd, a_rd1, a_rd2;

    reg_file_sb #(.WIDTH(RF_WIDTH), .NREGS(RF_NREGS)) dut16 (
        .clk(clk), .reset(a_rst), .rr1(a_rr1), .rr2(a_rr2), .rd1(a_rd1), .rd2(a_rd2),
        .busy1(a_b1), .busy2(a_b2), .regwrite(a_rw), .wr(a_wr), .wd(a_wd),
        .issue_valid(a_iv), .issue_rd(a_ird), .issue_ready(a_rdy)
    );

    // 32-bit x 8 instance
    logic        b_rst, b_rw, b_iv, b_b1, b_b2, b_rdy;
    logic [2:0]  b_wr, b_ird, b_rr1, b_rr2;
    logic [31:0] b_wd, b_rd1, b_rd2;

    reg_file_sb #(.WIDTH(32), .NREGS(8)) dut32 (
        .clk(clk), .reset(b_rst), .rr1(b_rr1), .rr2(b_rr2), .rd1(b_rd1), .rd2(b_rd2),
        .busy1(b_b1), .busy2(b_b2), .regwrite(b_rw), .wr(b_wr), .wd(b_wd),
        .issue_valid(b_iv), .issue_rd(b_ird), .issue_ready(b_rdy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, rw;
        logic [1:0]  wr;
        logic [15:0] wd;
        logic        iv;
        logic [1:0]  ird, rr1, rr2;
        logic [15:0] e1, e2;
        logic        eb1, eb2, erdy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rst, logic rw, logic [1:0] wr, logic [15:0] wd,
                                logic iv, logic [1:0] ird, logic [1:0] rr1, logic [1:0] rr2,
                                logic [15:0] e1, logic [15:0] e2,
                                logic eb1, logic eb2, logic erdy);
        vec_t v;
        v.rst = rst; v.rw = rw; v.wr = wr; v.wd = wd; v.iv = iv; v.ird = ird;
        v.rr1 = rr1; v.rr2 = rr2; v.e1 = e1; v.e2 = e2;
        v.eb1 = eb1; v.eb2 = eb2; v.erdy = erdy;
        return v;
    endfunction

    task automatic drive_a(logic rst, logic rw, logic [1:0] wr, logic [15:0] wd,
                           logic iv, logic [1:0] ird, logic [1:0] rr1, logic [1:0] rr2);
        a_rst = rst; a_rw = rw; a_wr = wr; a_wd = wd;
        a_iv = iv; a_ird = ird; a_rr1 = rr1; a_rr2 = rr2;
    endtask

    task automatic drive_b(logic rst, logic rw, logic [2:0] wr, logic [31:0] wd,
                           logic iv, logic [2:0] ird, logic [2:0] rr1);
        b_rst = rst; b_rw = rw; b_wr = wr; b_wd = wd;
        b_iv = iv; b_ird = ird; b_rr1 = rr1; b_rr2 = 3'd0;
    endtask

    // Behavioural model state for the random run
    logic [15:0] m_regs [4];
    bit          m_pend [4];

    initial begin
        drive_a(1'b1, 0, 0, 0, 0, 0, 0, 0);
        drive_b(1'b1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset after random writes and issues, held for two cycles
        for (int k = 0; k < 6; k++) begin
            drive_a(1'b0, 1'b1, 2'($urandom_range(1, 3)), 16'($urandom), 1'b1,
                    2'($urandom_range(1, 3)), 0, 0);
            @(negedge clk);
        end
        drive_a(1'b1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);

        //         rst rw wr wd        iv ird rr1 rr2  rd1      rd2     b1 b2 rdy
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 2, 16'h0000, 16'h0000, 0, 0, 1));
        tv.push_back(mk(0, 1, 1, 16'h000F, 0, 0, 1, 2, 16'h000F, 16'h0000, 0, 0, 1));
        tv.push_back(mk(0, 1, 2, 16'h0007, 0, 0, 1, 2, 16'h000F, 16'h0007, 0, 0, 1));
        tv.push_back(mk(0, 1, 0, 16'hFFFF, 0, 0, 0, 1, 16'h0000, 16'h000F, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 2, 16'h0000, 16'h0007, 0, 0, 1));
        tv.push_back(mk(0, 1, 3, 16'h0005, 0, 0, 3, 2, 16'h0005, 16'h0007, 0, 0, 1));
        tv.push_back(mk(0, 1, 3, 16'h0016, 0, 0, 3, 3, 16'h0016, 16'h0016, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 3, 3, 16'h0016, 16'h0016, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 2, 1, 16'h0007, 16'h000F, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 2, 2, 16'h0007, 16'h0007, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 2, 1, 16'h0007, 16'h000F, 1, 0, 0));
        tv.push_back(mk(0, 1, 2, 16'h0008, 0, 2, 2, 2, 16'h0008, 16'h0008, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 2, 2, 16'h0008, 16'h0008, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 1, 1, 1, 2, 16'h000F, 16'h0008, 0, 0, 1));
        tv.push_back(mk(0, 1, 1, 16'h0011, 1, 1, 1, 1, 16'h0011, 16'h0011, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 2, 16'h0011, 16'h0008, 1, 0, 0));
        tv.push_back(mk(0, 1, 1, 16'h0022, 0, 1, 1, 1, 16'h0022, 16'h0022, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 1, 2, 16'h0022, 16'h0008, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 3, 16'h0000, 16'h0016, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 2, 1, 16'h0008, 16'h0022, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 2, 1, 16'h0008, 16'h0022, 1, 0, 0));
        tv.push_back(mk(1, 1, 2, 16'h1234, 0, 2, 2, 1, 16'h1234, 16'h0022, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 2, 3, 16'h0000, 16'h0000, 0, 0, 1));

        foreach (tv[i]) begin
            drive_a(tv[i].rst, tv[i].rw, tv[i].wr, tv[i].wd, tv[i].iv, tv[i].ird,
                    tv[i].rr1, tv[i].rr2);
            #1;
            check($sformatf("vec%0d.rd1", i), 32'(a_rd1), 32'(tv[i].e1));
            check($sformatf("vec%0d.rd2", i), 32'(a_rd2), 32'(tv[i].e2));
            check($sformatf("vec%0d.busy1", i), 32'(a_b1), 32'(tv[i].eb1));
            check($sformatf("vec%0d.busy2", i), 32'(a_b2), 32'(tv[i].eb2));
            check($sformatf("vec%0d.ready", i), 32'(a_rdy), 32'(tv[i].erdy));
            @(negedge clk);
        end

        // Random run; the table leaves every register 0 and nothing pending
        for (int r = 0; r < 4; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        for (int k = 0; k < 400; k++) begin
            logic [15:0] e1, e2;
            bit eb1, eb2, erdy;
            drive_a(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0),
                    2'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1),
                    2'($urandom), 2'($urandom), 2'($urandom));
            #1;
            e1 = (a_rr1 == 0) ? 16'h0 : (a_rw && a_wr == a_rr1) ? a_wd : m_regs[a_rr1];
            e2 = (a_rr2 == 0) ? 16'h0 : (a_rw && a_wr == a_rr2) ? a_wd : m_regs[a_rr2];
            eb1 = (a_rr1 != 0) && m_pend[a_rr1] && !(a_rw && a_wr == a_rr1);
            eb2 = (a_rr2 != 0) && m_pend[a_rr2] && !(a_rw && a_wr == a_rr2);
            erdy = (a_ird == 0) || !m_pend[a_ird] || (a_rw && a_wr == a_ird);
            check("rand.rd1", 32'(a_rd1), 32'(e1));
            check("rand.rd2", 32'(a_rd2), 32'(e2));
            check("rand.busy1", 32'(a_b1), 32'(eb1));
            check("rand.busy2", 32'(a_b2), 32'(eb2));
            check("rand.ready", 32'(a_rdy), 32'(erdy));
            if (a_rst) begin
                for (int r = 0; r < 4; r++) begin
                    m_regs[r] = '0;
                    m_pend[r] = 1'b0;
                end
            end else begin
                if (a_rw && a_wr != 0) begin
                    m_regs[a_wr] = a_wd;
                    m_pend[a_wr] = 1'b0;
                end
                if (a_iv && erdy && a_ird != 0) m_pend[a_ird] = 1'b1;
            end
            @(negedge clk);
        end
        drive_a(1'b0, 0, 0, 0, 0, 0, 0, 0);

        // Wide instance: pending r7 then reset together with a writeback to r7
        drive_b(1'b0, 1'b1, 3'd7, 32'h1234_5678, 1'b0, 3'd0, 3'd7);
        #1;
        check("w32.bypass", b_rd1, 32'h1234_5678);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 3'd7);
        #1;
        check("w32.rd1_stored", b_rd1, 32'h1234_5678);
        check("w32.ready_free", 32'(b_rdy), 32'd1);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd7, 3'd7);
        #1;
        check("w32.busy_set", 32'(b_b1), 32'd1);
        check("w32.ready_blocked", 32'(b_rdy), 32'd0);
        @(negedge clk);
        drive_b(1'b1, 1'b1, 3'd7, 32'hDEAD_BEEF, 1'b1, 3'd7, 3'd7);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd7, 3'd7);
        #1;
        check("w32.rd1_after_reset", b_rd1, 32'h0);
        check("w32.busy_after_reset", 32'(b_b1), 32'd0);
        check("w32.ready_after_reset", 32'(b_rdy), 32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the pipelined 16-bit MIPS datapath. It replaces the fixed 4×16 file with configurable width and depth, and adds three things the old file lacks: a synchronous reset, write-to-read bypass, and a per-register scoreboard of pending writes. The decode stage uses the scoreboard to detect RAW hazards and stall, instead of relying on software-inserted nops. It sits between decode (read ports, issue) and writeback (write port).

## Interface
Parameters:
- WIDTH, 16, data word width in bits
- NREGS, 4, number of architectural registers (≥2, power of two); register 0 is hardwired zero
- ADDR_W, $clog2(NREGS), register index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rr1  in  ADDR_W  read port 1 index
- rr2  in  ADDR_W  read port 2 index
- rd1  out  WIDTH  read port 1 data (combinational)
- rd2  out  WIDTH  read port 2 data (combinational)
- busy1  out  1  rr1 has a pending write not satisfied by bypass this cycle
- busy2  out  1  same for rr2
- regwrite  in  1  writeback enable
- wr  in  ADDR_W  writeback index
- wd  in  WIDTH  writeback data
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of issued instruction
- issue_ready  out  1  issue_rd may be marked pending this cycle

## Operation
- Storage: NREGS-1 words, regs[1..NREGS-1]. Also pending[NREGS-1:1], one bit per register.
- Read: rdN = 0 if rrN==0. Otherwise, if regwrite && wr==rrN, rdN = wd (bypass). Otherwise rdN = regs[rrN].
- busyN = pending[rrN] && !(regwrite && wr==rrN). busyN is always 0 for rrN==0.
- Write: at the clock edge, if regwrite && wr!=0, then regs[wr] <= wd. Writes to register 0 are ignored.
- Scoreboard, per register i≥1, evaluated each edge:
  - clr = regwrite && wr==i
  - set = issue_valid && issue_ready && issue_rd==i
  - pending[i] <= set | (pending[i] & ~clr)
  - Simultaneous clear and set on the same register: set wins, so pending stays 1 for the new writer.
- issue_ready = (issue_rd==0) | ~pending[issue_rd] | (regwrite && wr==issue_rd). At most one outstanding write per register is allowed.
- Issue with issue_rd==0 is accepted and has no effect on state.
- Writeback to a non-pending register is legal: data is written and pending stays 0.
- Reset: regs all 0 and pending all 0 on the first rising edge with reset=1. Reset overrides any write or issue in the same cycle.
- Outputs after reset: rd1/rd2 = 0 unless bypass is active; busy1/busy2 = 0; issue_ready = 1.

## Timing
- Read latency 0: the read path is combinational from rr*/regwrite/wr/wd.
- Write latency 1: data is visible from regs on the cycle after the edge, and via bypass in the same cycle.
- Scoreboard set/clear takes effect the cycle after the edge. busy reflects the same-cycle writeback immediately through the bypass term.
- issue_ready is combinational. It must not depend on issue_valid, so there is no combinational loop with decode.
- No multicycle paths. Worst-case path: wr compare → bypass mux → rd.

## Structure
- Shared package rf_pkg: default WIDTH/NREGS constants and the ZERO_REG index constant. The CPU, forwarding unit and testbench import the same values from it.
- One sub-module, rf_word: a WIDTH-bit register with enable and synchronous reset. It is instantiated NREGS-1 times in a generate loop.
- The scoreboard and bypass logic are inline in reg_file_sb.

## Test plan
- Reset: hold reset 2 cycles after random writes → every rd = 0, busy = 0, issue_ready = 1.
- Basic write/read: write regs[1]=0x000F, regs[2]=0x0007 → next cycle rd1(rr1=1)=0x000F, rd2(rr2=2)=0x0007. Write to r0 with 0xFFFF → rd(0) stays 0.
- Bypass: regwrite, wr=3, wd=0x0016, rr1=3 in the same cycle → rd1=0x0016 and busy1=0 while regs[3] still holds its old value.
- Scoreboard hazard: issue rd=2 → next cycle rr1=2 gives busy1=1 and issue_ready(issue_rd=2)=0. Writeback wr=2 wd=0x0008 → busy1=0 that cycle, pending cleared the next.
- Simultaneous clear+set: pending[1]=1, writeback wr=1 and issue issue_rd=1 in the same cycle → issue_ready=1 and pending[1]=1 afterwards; a later writeback clears it.
- Reset mid-operation: pending[2]=1, then reset asserted together with regwrite wr=2 wd=0x1234 → regs[2]=0 and pending[2]=0 after the edge. Re-run with WIDTH=32, NREGS=8: same results on r7.
